// File: rtl/add_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and default geometry.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ADD_WIDTH = 16;
  localparam int ADD_DIGIT = 4;

  // Digit counter width; a single-digit configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_serial_if.sv
// Operand/result handshake bundle for add_serial.
// The sub line exists only when ADD_SERIAL_SUB_EN is defined.
interface add_serial_if
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             cin;
`ifdef ADD_SERIAL_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid,
    input  in_ready,
    output num1,
    output num2,
    output cin,
`ifdef ADD_SERIAL_SUB_EN
    output sub,
`endif
    input  out_valid,
    output out_ready,
    input  out,
    input  cout,
    input  ovf
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  num1,
    input  num2,
    input  cin,
`ifdef ADD_SERIAL_SUB_EN
    input  sub,
`endif
    output out_valid,
    input  out_ready,
    output out,
    output cout,
    output ovf
  );

endinterface

// File: rtl/add_digit.sv
// Combinational DIGIT-bit ripple adder used as the per-cycle slice of add_serial.
module add_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_bit
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign co = c[DIGIT];

endmodule

// File: rtl/add_serial.sv
// Digit-serial adder: sums DIGIT bits per cycle, LSB digit first, over WIDTH/DIGIT cycles.
// Optional subtraction mode is enabled by defining ADD_SERIAL_SUB_EN.
module add_serial
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int DIGIT = ADD_DIGIT
) (
  input  logic          clk,
  input  logic          rstn,
  add_serial_if.slave   bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;

  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             co_dig;
  logic [WIDTH-1:0] res;

  assign a_dig = a_reg[cnt_reg * DIGIT +: DIGIT];
  assign b_dig = b_reg[cnt_reg * DIGIT +: DIGIT];

  add_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a  (a_dig),
    .b  (b_dig),
    .ci (carry_reg),
    .s  (s_dig),
    .co (co_dig)
  );

  // Partial sum with the current digit merged in; becomes the result on the last digit.
  always_comb begin
    res = acc_reg;
    res[cnt_reg * DIGIT +: DIGIT] = s_dig;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      out_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
      out_reg   <= out_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    out_next   = out_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = RUN;
          cnt_next   = '0;
          a_next     = bus.num1;
`ifdef ADD_SERIAL_SUB_EN
          // Subtraction is a + ~b + 1; b is stored already inverted so ovf uses one rule.
          if (bus.sub) begin
            b_next     = ~bus.num2;
            carry_next = 1'b1;
          end else begin
            b_next     = bus.num2;
            carry_next = bus.cin;
          end
`else
          b_next     = bus.num2;
          carry_next = bus.cin;
`endif
        end
      end

      RUN: begin
        acc_next   = res;
        carry_next = co_dig;
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == LAST) begin
          state_next = DONE;
          cnt_next   = '0;
          out_next   = res;
          cout_next  = co_dig;
          ovf_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                       (res[WIDTH-1] != a_reg[WIDTH-1]);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out       = out_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_add_serial.sv
// Randomized and directed bench for add_serial in 16/4, 4/4 and 8/1 geometries.
// Define ADD_SERIAL_SUB_EN to also exercise subtraction on the 16/4 instance.
module tb_add_serial;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  add_serial_if #(.WIDTH(16)) bus16 ();
  add_serial_if #(.WIDTH(4))  bus4 ();
  add_serial_if #(.WIDTH(8))  bus8 ();

  add_serial #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rstn(rstn), .bus(bus16));
  add_serial #(.WIDTH(4),  .DIGIT(4)) dut4  (.clk(clk), .rstn(rstn), .bus(bus4));
  add_serial #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rstn(rstn), .bus(bus8));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic ordy);
    case (sel)
      0: begin
        bus16.in_valid = v; bus16.num1 = a; bus16.num2 = b; bus16.cin = c; bus16.out_ready = ordy;
      end
      1: begin
        bus4.in_valid = v; bus4.num1 = a[3:0]; bus4.num2 = b[3:0]; bus4.cin = c; bus4.out_ready = ordy;
      end
      default: begin
        bus8.in_valid = v; bus8.num1 = a[7:0]; bus8.num2 = b[7:0]; bus8.cin = c; bus8.out_ready = ordy;
      end
    endcase
  endtask

  task automatic set_sub(input logic s);
`ifdef ADD_SERIAL_SUB_EN
    bus16.sub = s;
    bus4.sub  = s;
    bus8.sub  = s;
`else
    if (s) $display("note: sub requested but subtraction is not built");
`endif
  endtask

  task automatic sample(input int sel, output logic ir, output logic ov, output logic [15:0] o,
                        output logic co, output logic of);
    case (sel)
      0: begin
        ir = bus16.in_ready; ov = bus16.out_valid; o = bus16.out; co = bus16.cout; of = bus16.ovf;
      end
      1: begin
        ir = bus4.in_ready; ov = bus4.out_valid; o = {12'h000, bus4.out}; co = bus4.cout; of = bus4.ovf;
      end
      default: begin
        ir = bus8.in_ready; ov = bus8.out_valid; o = {8'h00, bus8.out}; co = bus8.cout; of = bus8.ovf;
      end
    endcase
  endtask

  // One full transaction: accept, wait for the result, hold it, then release it.
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input int hold);
    int w, n, cyc, mask, half, aa, bb, full, sa, sb, sres;
    logic ir, ov, co, of;
    logic [15:0] o;
    logic [15:0] exp_o;
    logic exp_co, exp_of, busy_ok, stable_ok;
    string p;

    w = (sel == 0) ? 16 : (sel == 1) ? 4 : 8;
    n = (sel == 0) ? 4 : (sel == 1) ? 1 : 8;
    p = $sformatf("w%0d", w);

    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    aa = int'(a) & mask;
    bb = int'(b) & mask;
    if (s) full = aa + ((~bb) & mask) + 1;
    else   full = aa + bb + int'(c);
    exp_o  = 16'(full & mask);
    exp_co = ((full >> w) & 1) != 0;
    sa = (aa >= half) ? aa - (1 << w) : aa;
    sb = (bb >= half) ? bb - (1 << w) : bb;
    sres = s ? (sa - sb) : (sa + sb + int'(c));
    exp_of = (sres >= half) || (sres < -half);

    @(negedge clk);
    sample(sel, ir, ov, o, co, of);
    check_val({p, "_ready_before"}, 32'(ir), 32'd1);
    drive(sel, 1'b1, a, b, c, 1'b0);
    set_sub(s);
    @(posedge clk);
    @(negedge clk);
    // Garbage on the operand lines with in_valid high must not disturb the running op.
    drive(sel, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    set_sub(1'($urandom));
    cyc = 0;
    busy_ok = 1'b1;
    sample(sel, ir, ov, o, co, of);
    while (!ov && cyc < 64) begin
      if (ir) busy_ok = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      sample(sel, ir, ov, o, co, of);
    end
    check_val({p, "_latency"}, 32'(cyc), 32'(n));
    check_val({p, "_busy_not_ready"}, 32'(busy_ok), 32'd1);
    check_val({p, "_out"}, 32'(o), 32'(exp_o));
    check_val({p, "_cout"}, 32'(co), 32'(exp_co));
    check_val({p, "_ovf"}, 32'(of), 32'(exp_of));

    stable_ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      sample(sel, ir, ov, o, co, of);
      if (!ov || ir || o !== exp_o || co !== exp_co || of !== exp_of) stable_ok = 1'b0;
    end
    if (hold > 0) check_val({p, "_hold_stable"}, 32'(stable_ok), 32'd1);

    drive(sel, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    set_sub(1'b0);
    sample(sel, ir, ov, o, co, of);
    check_val({p, "_released_valid"}, 32'(ov), 32'd0);
    check_val({p, "_released_ready"}, 32'(ir), 32'd1);
    check_val({p, "_out_kept"}, 32'(o), 32'(exp_o));
    $display("txn %s a=0x%0h b=0x%0h cin=%0d sub=%0d -> out=0x%0h cout=%0d ovf=%0d lat=%0d",
             p, aa, bb, c, s, o, co, of, cyc);
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic ir, ov, co, of;
    logic [15:0] o;
    bit sub_on;

`ifdef ADD_SERIAL_SUB_EN
    sub_on = 1'b1;
`else
    sub_on = 1'b0;
`endif

    for (int s = 0; s < 3; s++) drive(s, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    set_sub(1'b0);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sample(s, ir, ov, o, co, of);
      check_val($sformatf("reset%0d_ready", s), 32'(ir), 32'd1);
      check_val($sformatf("reset%0d_valid", s), 32'(ov), 32'd0);
      check_val($sformatf("reset%0d_out", s), 32'(o), 32'd0);
      check_val($sformatf("reset%0d_cout_ovf", s), {30'd0, co, of}, 32'd0);
    end
    rstn = 1'b1;

    // Directed corner cases on the 16/4 and 8/1 instances.
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 5);
    run_op(2, 16'h00AB, 16'h0055, 1'b1, 1'b0, 1);

    // Reset while running on the 16/4 instance abandons the operation.
    @(negedge clk);
    drive(0, 1'b1, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    sample(0, ir, ov, o, co, of);
    check_val("rst_run_ready", 32'(ir), 32'd1);
    check_val("rst_run_valid", 32'(ov), 32'd0);
    check_val("rst_run_out", 32'(o), 32'd0);
    check_val("rst_run_cout_ovf", {30'd0, co, of}, 32'd0);
    begin
      bit no_pulse;
      no_pulse = 1'b1;
      repeat (8) begin
        @(posedge clk);
        @(negedge clk);
        sample(0, ir, ov, o, co, of);
        if (ov) no_pulse = 1'b0;
      end
      check_val("rst_run_no_pulse", 32'(no_pulse), 32'd1);
    end
    run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    if (sub_on) begin
      run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 0);
      run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    end

    // Exhaustive single-digit configuration.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_op(1, 16'(i), 16'(j), 1'b0, 1'b0, 0);

    // Randomized traffic.
    for (int k = 0; k < 120; k++)
      run_op(0, pick16(), pick16(), 1'($urandom), sub_on ? 1'($urandom) : 1'b0, $urandom_range(0, 3));
    for (int k = 0; k < 40; k++)
      run_op(2, pick16(), pick16(), 1'($urandom), 1'b0, $urandom_range(0, 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/add_serial.md
ADD_SERIAL -- requirements
Module: add_serial

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of DIGIT, min 4.
REQ-002 Parameter DIGIT, default 4, bits summed per cycle; SHALL divide WIDTH; N = WIDTH/DIGIT is the digit count.
REQ-003 Port clk  input  1  single clock; every register updates on the rising edge.
REQ-004 Port rstn  input  1  reset, synchronous, active-low.
REQ-005 Port in_valid  input  1  operands valid.
REQ-006 Port in_ready  output  1  block accepts operands.
REQ-007 Port num1, num2  input  WIDTH each  unsigned/two's-complement operands.
REQ-008 Port cin  input  1  carry-in.
REQ-009 Port out_valid  output  1  result valid.
REQ-010 Port out_ready  input  1  consumer accepts result.
REQ-011 Port out  output  WIDTH  sum.
REQ-012 Port cout  output  1  carry-out of the MSB.
REQ-013 Port ovf  output  1  signed overflow: operand MSBs equal, out MSB differs.

Function
REQ-014 FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 Accept = in_valid & in_ready; on accept, num1, num2, cin are latched and the state moves IDLE->RUN with digit counter 0.
REQ-016 Inputs num1/num2/cin SHALL be ignored outside the accept cycle.
REQ-017 In RUN, each cycle adds digit i (LSB first) of both operands plus the stored carry, writes DIGIT result bits, updates the carry, increments i.
REQ-018 After the edge that processes digit N-1, state -> DONE; out_valid rises exactly N cycles after the accept edge.
REQ-019 {cout, out} SHALL equal num1 + num2 + cin modulo 2^(WIDTH+1), for every operand pair.
REQ-020 In DONE, out, cout, ovf SHALL hold stable while out_ready=0; out_ready=1 moves DONE->IDLE.
REQ-021 No new operand is accepted in RUN or DONE; back-to-back throughput is one result per N+2 cycles.
REQ-022 out/cout/ovf are undefined-free: they hold the last completed result (or reset value) outside DONE.
REQ-023 DIGIT == WIDTH SHALL work: RUN lasts one cycle.

Reset
REQ-024 rstn=0 at a clock edge forces IDLE, counter 0, stored carry 0, out=0, cout=0, ovf=0, out_valid=0, in_ready=1 on the next cycle.
REQ-025 Reset during RUN or DONE abandons the operation; no out_valid pulse is produced for it.

Configuration
REQ-026 Macro ADD_SERIAL_SUB_EN: when defined, add port sub input 1, latched at accept.
REQ-027 With ADD_SERIAL_SUB_EN and sub=1: result = num1 - num2 (num2 inverted, cin ignored, carry-in forced 1); cout=1 means no borrow; ovf is signed subtraction overflow.
REQ-028 Without ADD_SERIAL_SUB_EN: no sub port; behaviour is addition only, as in REQ-019.

Structure
REQ-029 Shared package add_pkg holds the state enum (IDLE, RUN, DONE) and the default WIDTH/DIGIT constants.
REQ-030 One sub-module add_digit: combinational DIGIT-bit adder (a, b, ci -> s, co), instantiated once in add_serial.

Verification
REQ-031 WIDTH=16, DIGIT=4: num1=0xFFFF, num2=0x0001, cin=0 -> out=0x0000, cout=1, ovf=0, out_valid 4 cycles after accept.
REQ-032 WIDTH=16, DIGIT=4: num1=0x7FFF, num2=0x0001 -> out=0x8000, cout=0, ovf=1; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-033 WIDTH=4, DIGIT=4: exhaustive i,j in 0..15, cin=0 -> {cout,out} == i+j for all 256 pairs, out_valid 1 cycle after accept.
REQ-034 WIDTH=16, DIGIT=4: accept 0x1234+0x0FFF, rstn=0 on cycle 2 of RUN -> next cycle in_ready=1, out_valid=0, out=0; subsequent 0x0001+0x0001 -> out=0x0002.
REQ-035 ADD_SERIAL_SUB_EN, WIDTH=16: sub=1, num1=0x0005, num2=0x0007 -> out=0xFFFE, cout=0; num1=0x8000, num2=0x0001 -> out=0x7FFF, ovf=1.
REQ-036 WIDTH=8, DIGIT=1: 0xAB+0x55, cin=1 -> out=0x01, cout=1, out_valid 8 cycles after accept.
